// File: rtl/ddr_mem_bridge.sv
// PicoRV32 native memory port to word-wide DDR port bridge; partial-strobe writes become read-modify-write.
// Registered outputs; read 3, full write 2, RMW 4 cycles to mem_ready; a missing rd_valid aborts with bus_err.
module ddr_mem_bridge #(
  parameter int          DATA_WIDTH = 32,
  parameter int          DEPTH      = 1024,
  parameter int          TIMEOUT    = 15,
  parameter logic [31:0] ERR_DATA   = 32'hDEADBEEF,
  localparam int         ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_valid,
  input  logic [31:0]           mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [3:0]            mem_wstrb,
  output logic                  mem_ready,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  bus_err,
  output logic                  ddr_rd_req,
  output logic                  ddr_wr_req,
  output logic [ADDR_W-1:0]     ddr_addr,
  output logic [DATA_WIDTH-1:0] ddr_wr_data,
  input  logic [DATA_WIDTH-1:0] ddr_rd_data,
  input  logic                  ddr_rd_valid
);

  typedef enum logic [2:0] {IDLE, RD_WAIT, RMW_WAIT, WR, RESP} state_t;

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

  state_t                state, state_nxt;
  logic [7:0]            wait_cnt, wait_cnt_nxt;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [3:0]            wstrb_q;
  logic [DATA_WIDTH-1:0] merged;
  logic                  accept;
  logic                  timed_out;

  logic                  mem_ready_nxt;
  logic                  bus_err_nxt;
  logic                  ddr_rd_req_nxt;
  logic                  ddr_wr_req_nxt;
  logic [ADDR_W-1:0]     ddr_addr_nxt;
  logic [DATA_WIDTH-1:0] ddr_wr_data_nxt;
  logic [DATA_WIDTH-1:0] mem_rdata_nxt;

  logic                  unused_addr_bits;
  assign unused_addr_bits = ^{mem_addr[31:ADDR_W+2], mem_addr[1:0]};

  // The CPU still holds mem_valid during the mem_ready cycle, so it must not restart a transaction.
  assign accept    = mem_valid && !mem_ready;
  assign timed_out = (wait_cnt == TO_LIMIT) && !ddr_rd_valid;

  always_comb begin
    merged = ddr_rd_data;
    for (int i = 0; i < 4; i++) begin
      if (wstrb_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wait_cnt    <= 8'd0;
      wdata_q     <= '0;
      wstrb_q     <= 4'h0;
      mem_ready   <= 1'b0;
      bus_err     <= 1'b0;
      ddr_rd_req  <= 1'b0;
      ddr_wr_req  <= 1'b0;
      ddr_addr    <= '0;
      ddr_wr_data <= '0;
      mem_rdata   <= '0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_cnt_nxt;
      mem_ready   <= mem_ready_nxt;
      bus_err     <= bus_err_nxt;
      ddr_rd_req  <= ddr_rd_req_nxt;
      ddr_wr_req  <= ddr_wr_req_nxt;
      ddr_addr    <= ddr_addr_nxt;
      ddr_wr_data <= ddr_wr_data_nxt;
      mem_rdata   <= mem_rdata_nxt;
      if (state == IDLE && accept) begin
        wdata_q <= mem_wdata;
        wstrb_q <= mem_wstrb;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (mem_wstrb == 4'h0)      state_nxt = RD_WAIT;
          else if (mem_wstrb == 4'hF) state_nxt = RESP;
          else                        state_nxt = RMW_WAIT;
        end
      end
      RD_WAIT: begin
        if (ddr_rd_valid || timed_out) state_nxt = IDLE;
      end
      RMW_WAIT: begin
        if (ddr_rd_valid)   state_nxt = WR;
        else if (timed_out) state_nxt = IDLE;
      end
      WR:      state_nxt = IDLE;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_ready_nxt   = 1'b0;
    bus_err_nxt     = 1'b0;
    ddr_rd_req_nxt  = 1'b0;
    ddr_wr_req_nxt  = 1'b0;
    ddr_addr_nxt    = ddr_addr;
    ddr_wr_data_nxt = ddr_wr_data;
    mem_rdata_nxt   = mem_rdata;
    wait_cnt_nxt    = wait_cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          ddr_addr_nxt = mem_addr[ADDR_W+1:2];
          wait_cnt_nxt = 8'd0;
          if (mem_wstrb == 4'hF) begin
            ddr_wr_req_nxt  = 1'b1;
            ddr_wr_data_nxt = mem_wdata;
          end else begin
            ddr_rd_req_nxt  = 1'b1;
          end
        end
      end
      RD_WAIT: begin
        if (ddr_rd_valid) begin
          mem_ready_nxt = 1'b1;
          mem_rdata_nxt = ddr_rd_data;
        end else if (timed_out) begin
          mem_ready_nxt = 1'b1;
          bus_err_nxt   = 1'b1;
          mem_rdata_nxt = ERR_DATA;
        end else begin
          wait_cnt_nxt  = wait_cnt + 8'd1;
        end
      end
      RMW_WAIT: begin
        // A timed-out RMW reports the error and never issues its write half.
        if (ddr_rd_valid) begin
          ddr_wr_req_nxt  = 1'b1;
          ddr_wr_data_nxt = merged;
        end else if (timed_out) begin
          mem_ready_nxt = 1'b1;
          bus_err_nxt   = 1'b1;
          mem_rdata_nxt = ERR_DATA;
        end else begin
          wait_cnt_nxt  = wait_cnt + 8'd1;
        end
      end
      WR:      mem_ready_nxt = 1'b1;
      RESP:    mem_ready_nxt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ddr_mem_bridge.sv
// Bench for ddr_mem_bridge: DDR responder model, byte-mask reference memory, directed then random accesses.
module tb_ddr_mem_bridge;
  localparam int          DEPTH    = 1024;
  localparam int          ADDR_W   = 10;
  localparam int          TIMEOUT  = 15;
  localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

  logic              clk = 1'b0;
  logic              reset;
  logic              mem_valid;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;
  logic              mem_ready;
  logic [31:0]       mem_rdata;
  logic              bus_err;
  logic              ddr_rd_req;
  logic              ddr_wr_req;
  logic [ADDR_W-1:0] ddr_addr;
  logic [31:0]       ddr_wr_data;
  logic [31:0]       ddr_rd_data;
  logic              ddr_rd_valid;

  ddr_mem_bridge #(
    .DATA_WIDTH(32), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)
  ) dut (
    .clk(clk), .reset(reset),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .bus_err(bus_err),
    .ddr_rd_req(ddr_rd_req), .ddr_wr_req(ddr_wr_req), .ddr_addr(ddr_addr),
    .ddr_wr_data(ddr_wr_data), .ddr_rd_data(ddr_rd_data), .ddr_rd_valid(ddr_rd_valid)
  );

  always #5 clk = ~clk;

  int n_asserts = 0;
  int n_fail    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] init_val(input int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'hA5A5_0000;
  endfunction

  // DDR word memory: one-cycle read latency, whole-word writes, optional silent responder
  logic [31:0]       mem [DEPTH];
  logic              mem_init    = 1'b0;
  logic              pre_we      = 1'b0;
  logic [ADDR_W-1:0] pre_idx     = '0;
  logic [31:0]       pre_dat     = '0;
  logic              responder_en = 1'b1;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_val(i);
    end
    if (pre_we) mem[pre_idx] <= pre_dat;
    if (ddr_wr_req) mem[ddr_addr] <= ddr_wr_data;
    ddr_rd_valid <= ddr_rd_req && responder_en && !reset;
    if (ddr_rd_req) ddr_rd_data <= mem[ddr_addr];
  end

  // Protocol monitor on the falling edge
  int                rd_cnt = 0;
  int                wr_cnt = 0;
  logic [ADDR_W-1:0] last_rd_addr = '0;
  logic [ADDR_W-1:0] last_wr_addr = '0;
  logic [31:0]       last_wr_data = '0;
  logic              prev_ready = 1'b0, prev_rd = 1'b0, prev_wr = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      check("req_overlap", 32'(ddr_rd_req && ddr_wr_req), 32'd0);
      check("ready_pulse", 32'(mem_ready && prev_ready), 32'd0);
      check("rd_req_pulse", 32'(ddr_rd_req && prev_rd), 32'd0);
      check("wr_req_pulse", 32'(ddr_wr_req && prev_wr), 32'd0);
      check("err_wo_ready", 32'(bus_err && !mem_ready), 32'd0);
    end
    if (ddr_rd_req) begin
      rd_cnt++;
      last_rd_addr = ddr_addr;
    end
    if (ddr_wr_req) begin
      wr_cnt++;
      last_wr_addr = ddr_addr;
      last_wr_data = ddr_wr_data;
    end
    prev_ready = mem_ready;
    prev_rd    = ddr_rd_req;
    prev_wr    = ddr_wr_req;
  end

  // Reference state
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] exp_rdata = 32'd0;

  task automatic preload(input int idx, input logic [31:0] val);
    pre_idx = ADDR_W'(idx);
    pre_dat = val;
    pre_we  = 1'b1;
    @(posedge clk); #1;
    pre_we  = 1'b0;
    ref_mem[idx] = val;
  endtask

  // One CPU transaction; the reference outcome comes from strobe class and responder availability.
  task automatic access(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                        input bit hold, input bit drop, input string tag);
    int          idx, lat, lat_exp, rd0, wr0, rd_exp, wr_exp;
    bit          to, done;
    logic [31:0] mask;
    idx  = int'(addr[ADDR_W+1:2]);
    to   = !responder_en && (wstrb != 4'hF);
    mask = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
    lat_exp = to ? TIMEOUT + 2 : (wstrb == 4'h0) ? 3 : (wstrb == 4'hF) ? 2 : 4;
    rd_exp  = (wstrb == 4'hF) ? 0 : 1;
    wr_exp  = (wstrb == 4'h0 || to) ? 0 : 1;
    if (to) exp_rdata = ERR_DATA;
    else if (wstrb == 4'h0) exp_rdata = ref_mem[idx];
    else ref_mem[idx] = (ref_mem[idx] & ~mask) | (wdata & mask);

    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = wstrb;
    mem_valid = 1'b1;
    if (mem_ready) begin
      @(posedge clk); #1;
    end
    rd0  = rd_cnt;
    wr0  = wr_cnt;
    lat  = 0;
    done = 1'b0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (drop && lat == 1) mem_valid = 1'b0;
      if (mem_ready) done = 1'b1;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_lat"}, 32'(lat), 32'(lat_exp));
    check({tag, "_rdata"}, mem_rdata, exp_rdata);
    check({tag, "_err"}, 32'(bus_err), 32'(to));
    check({tag, "_nrd"}, 32'(rd_cnt - rd0), 32'(rd_exp));
    check({tag, "_nwr"}, 32'(wr_cnt - wr0), 32'(wr_exp));
    if (rd_exp == 1) check({tag, "_rdaddr"}, 32'(last_rd_addr), 32'(idx));
    if (wr_exp == 1) check({tag, "_wraddr"}, 32'(last_wr_addr), 32'(idx));
    check({tag, "_mem"}, mem[idx], ref_mem[idx]);
    if (!hold) mem_valid = 1'b0;
  endtask

  initial begin
    int          wr_before;
    logic [31:0] r, addr;
    logic [3:0]  ws;
    int          idx, sel;

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
    reset     = 1'b1;
    mem_init  = 1'b1;
    mem_valid = 1'b1;
    mem_addr  = 32'h14;
    mem_wdata = 32'h0;
    mem_wstrb = 4'h0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      mem_init = 1'b0;
      check("rst_rd_req", 32'(ddr_rd_req), 32'd0);
    end
    check("rst_ready", 32'(mem_ready), 32'd0);
    check("rst_rdata", mem_rdata, 32'd0);
    check("rst_err", 32'(bus_err), 32'd0);
    check("rst_wr_req", 32'(ddr_wr_req), 32'd0);
    check("rst_addr", 32'(ddr_addr), 32'd0);
    check("rst_wr_data", ddr_wr_data, 32'd0);
    check("rst_nreq", 32'(rd_cnt + wr_cnt), 32'd0);
    mem_valid = 1'b0;
    reset     = 1'b0;
    @(posedge clk); #1;

    preload(5, 32'h1234_5678);
    access(32'h0000_0014, 32'h0, 4'h0, 1'b0, 1'b0, "read");
    check("read_value", mem_rdata, 32'h1234_5678);
    access(32'h0000_0020, 32'hCAFE_F00D, 4'hF, 1'b0, 1'b0, "fullwr");
    access(32'h0000_0020, 32'h0, 4'h0, 1'b0, 1'b0, "readback");
    check("readback_value", mem_rdata, 32'hCAFE_F00D);
    access(32'h0000_0020, 32'h0000_AB00, 4'b0010, 1'b0, 1'b0, "rmw");
    check("rmw_wr_data", last_wr_data, 32'hCAFE_AB0D);

    responder_en = 1'b0;
    access(32'h0000_0014, 32'h0, 4'h0, 1'b0, 1'b0, "to_rd");
    access(32'h0000_0020, 32'h0000_0011, 4'b0001, 1'b0, 1'b0, "to_rmw");
    responder_en = 1'b1;

    for (int b = 0; b < 4; b++)
      access(32'(b + 3) << 2, 32'h0, 4'h0, b != 3, 1'b0, "b2b");

    // Reset while waiting for the read half of an RMW
    responder_en = 1'b0;
    mem_addr  = 32'h20;
    mem_wdata = 32'h0000_0077;
    mem_wstrb = 4'b0001;
    mem_valid = 1'b1;
    if (mem_ready) begin
      @(posedge clk); #1;
    end
    wr_before = wr_cnt;
    repeat (3) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_ready", 32'(mem_ready), 32'd0);
    check("midrst_err", 32'(bus_err), 32'd0);
    check("midrst_reqs", 32'(ddr_rd_req || ddr_wr_req), 32'd0);
    check("midrst_rdata", mem_rdata, 32'd0);
    mem_valid    = 1'b0;
    reset        = 1'b0;
    responder_en = 1'b1;
    exp_rdata    = 32'd0;
    repeat (20) begin
      @(posedge clk); #1;
    end
    check("midrst_no_wr", 32'(wr_cnt - wr_before), 32'd0);
    check("midrst_mem", mem[8], ref_mem[8]);

    access(32'hFFFF_F015, 32'h0, 4'h0, 1'b0, 1'b1, "drop_rd");
    access(32'h8000_0032, 32'h5500_0000, 4'b1000, 1'b0, 1'b1, "drop_rmw");

    for (int it = 0; it < 40; it++) begin
      idx  = $urandom_range(0, 15);
      r    = $urandom;
      addr = (r & 32'hFFFF_F003) | (32'(idx) << 2);
      sel  = $urandom_range(0, 3);
      ws   = (sel == 0) ? 4'h0 : (sel == 1) ? 4'hF : 4'($urandom_range(1, 14));
      responder_en = ($urandom_range(0, 7) != 0);
      access(addr, $urandom, ws, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, "rnd");
    end
    responder_en = 1'b1;
    mem_valid    = 1'b0;
    repeat (4) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
